// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
//
// Sequencing controller for an external WIDTH-bit parallel-access shift
// register (ports R, L, w, Q). A start request captures a parallel word,
// a shift count (clamped to WIDTH) and a fill bit. The controller then
// loads the word into the register and shifts it right the requested number
// of times, presenting each outgoing bit on serial_out.
//
// The register has no enable, so outside LOAD and SHIFT the controller
// feeds Q back into R with L=1 to freeze the contents.
//
// Ports:
//   Clock      in   rising-edge clock shared with the shift register
//   Resetn     in   asynchronous, active-low reset
//   start      in   request, accepted only while ready=1
//   data_in    in   word to load (WIDTH bits)
//   nshift     in   number of right shifts (CW bits), clamped to WIDTH
//   fill       in   bit shifted into the MSB on every shift
//   Q          in   shift register output, fed back
//   R          out  register parallel input
//   L          out  register load control (1 = load/hold, 0 = shift)
//   w          out  register serial input
//   ready      out  idle, a start will be accepted
//   busy       out  high in LOAD and SHIFT
//   done       out  one-cycle completion pulse
//   serial_out out  Q[0] during a shift cycle, 0 otherwise
//   sout_valid out  high in each shift cycle
// ---------------------------------------------------------------------------
module shift_seq_ctrl #(
    parameter int WIDTH = 4,
    parameter int CW    = 3
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CW-1:0]    nshift,
    input  logic             fill,
    input  logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             L,
    output logic             w,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic             serial_out,
    output logic             sout_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] MAX_CNT = CW'(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] data_r;
    logic [CW-1:0]    cnt;
    logic             fill_r;
    logic [CW-1:0]    nshift_clamped;
    logic             accept;

    // Requests asking for more shifts than the register holds behave as a
    // full-width shift.
    assign nshift_clamped = (nshift > MAX_CNT) ? MAX_CNT : nshift;
    assign accept         = (state == IDLE) && start;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request capture on the accepting edge, then one count per shift.
    // Inputs are only sampled here, so changes at other times are ignored.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            data_r <= '0;
            cnt    <= '0;
            fill_r <= 1'b0;
        end else if (accept) begin
            data_r <= data_in;
            cnt    <= nshift_clamped;
            fill_r <= fill;
        end else if (state == SHIFT) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Next-state and output decode. The default drive is the hold pattern
    // (recirculate Q with L=1), so only LOAD and SHIFT override it.
    always_comb begin
        state_next = state;
        R          = Q;
        L          = 1'b1;
        w          = 1'b0;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        serial_out = 1'b0;
        sout_valid = 1'b0;

        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                R    = data_r;
                busy = 1'b1;
                state_next = (cnt == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                // R is ignored by the register while L=0; data_r keeps it
                // stable rather than following Q.
                R          = data_r;
                L          = 1'b0;
                w          = fill_r;
                busy       = 1'b1;
                serial_out = Q[0];
                sout_valid = 1'b1;
                if (cnt == CW'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_seq_ctrl
//
// Self-checking bench for shift_seq_ctrl. A behavioural model of the 4-bit
// shift register closes the loop on R/L/w/Q. Expected serial bits, final
// register contents and done latency come from plain arithmetic on the
// requested word, shift count and fill bit.
// ---------------------------------------------------------------------------
module tb_shift_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CW    = 3;

    logic             Clock = 1'b0;
    logic             Resetn;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [CW-1:0]    nshift;
    logic             fill;
    logic [WIDTH-1:0] Q = 4'b0110;
    logic [WIDTH-1:0] R;
    logic             L;
    logic             w;
    logic             ready;
    logic             busy;
    logic             done;
    logic             serial_out;
    logic             sout_valid;

    int checks = 0;
    int errors = 0;

    shift_seq_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
        .Clock      (Clock),
        .Resetn     (Resetn),
        .start      (start),
        .data_in    (data_in),
        .nshift     (nshift),
        .fill       (fill),
        .Q          (Q),
        .R          (R),
        .L          (L),
        .w          (w),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .serial_out (serial_out),
        .sout_valid (sout_valid)
    );

    always #5 Clock = ~Clock;

    // The external parallel-access shift register being sequenced.
    always @(posedge Clock) begin
        if (L) Q <= R;
        else   Q <= {w, Q[WIDTH-1:1]};
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic randomize_inputs();
        data_in = WIDTH'($urandom);
        nshift  = CW'($urandom);
        fill    = 1'($urandom);
    endtask

    // One complete request from IDLE back to IDLE. inject_at >= 1 pulses a
    // competing start with data 1111 before that edge after acceptance.
    task automatic run_op(input logic [WIDTH-1:0] d, input logic [CW-1:0] ns,
                          input logic f, input int inject_at, input string name);
        int               n;
        int               e;
        int               done_at;
        int               busy_cnt;
        logic [WIDTH-1:0] exp_q;
        logic             got_bits[$];

        n = (int'(ns) > WIDTH) ? WIDTH : int'(ns);
        e = int'(d) >> n;
        if (f) e = e | (((1 << n) - 1) << (WIDTH - n));
        exp_q = e[WIDTH-1:0];

        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s ready_before_start: got %b expected 1", name, ready);
        end

        start   = 1'b1;
        data_in = d;
        nshift  = ns;
        fill    = f;
        step();
        start = 1'b0;
        randomize_inputs();

        checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s load_state: got busy=%b ready=%b expected busy=1 ready=0",
                     name, busy, ready);
        end

        done_at  = -1;
        busy_cnt = 1;
        for (int cyc = 1; cyc <= 2 * WIDTH + 4; cyc++) begin
            randomize_inputs();
            start = (cyc == inject_at);
            if (start) data_in = 4'b1111;
            step();
            start = 1'b0;
            if (cyc == 1) begin
                checks++;
                if (Q !== d) begin
                    errors++;
                    $display("[TB] FAIL %s loaded_word: got %b expected %b", name, Q, d);
                end
            end
            if (sout_valid === 1'b1) got_bits.push_back(serial_out);
            if (done === 1'b1) begin
                done_at = cyc;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
        end

        checks++;
        if (done_at != n + 1) begin
            errors++;
            $display("[TB] FAIL %s done_latency: got %0d expected %0d", name, done_at, n + 1);
        end
        checks++;
        if (got_bits.size() != n) begin
            errors++;
            $display("[TB] FAIL %s shift_count: got %0d expected %0d", name, got_bits.size(), n);
        end
        for (int i = 0; i < n && i < got_bits.size(); i++) begin
            checks++;
            if (got_bits[i] !== d[i]) begin
                errors++;
                $display("[TB] FAIL %s serial_bit%0d: got %b expected %b", name, i, got_bits[i], d[i]);
            end
        end
        checks++;
        if (busy_cnt != n + 1) begin
            errors++;
            $display("[TB] FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, n + 1);
        end
        checks++;
        if (Q !== exp_q) begin
            errors++;
            $display("[TB] FAIL %s final_q: got %b expected %b", name, Q, exp_q);
        end

        step();
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s after_done: got done=%b ready=%b expected done=0 ready=1",
                     name, done, ready);
        end
        checks++;
        if (Q !== exp_q) begin
            errors++;
            $display("[TB] FAIL %s q_after_done: got %b expected %b", name, Q, exp_q);
        end
    endtask

    task automatic test_reset();
        Resetn = 1'b0;
        start  = 1'b0;
        randomize_inputs();
        #2;
        checks++;
        if (L !== 1'b1 || w !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 ||
            serial_out !== 1'b0 || sout_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got L=%b w=%b ready=%b busy=%b done=%b so=%b sv=%b expected 1 0 1 0 0 0 0",
                     L, w, ready, busy, done, serial_out, sout_valid);
        end
        checks++;
        if (R !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL reset_r_follows_q: got %b expected 0110", R);
        end
        start   = 1'b1;
        data_in = 4'b1001;
        for (int i = 0; i < 3; i++) step();
        start = 1'b0;
        checks++;
        if (Q !== 4'b0110 || ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_hold: got Q=%b ready=%b expected Q=0110 ready=1", Q, ready);
        end
        Resetn = 1'b1;
        step();
    endtask

    task automatic test_full_shift();
        run_op(4'b1010, 3'd4, 1'b0, -1, "full_shift");
    endtask

    task automatic test_hold();
        run_op(4'b1001, 3'd2, 1'b1, -1, "fill_one");
        for (int i = 0; i < 10; i++) begin
            randomize_inputs();
            step();
        end
        checks++;
        if (Q !== 4'b1110 || ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_idle: got Q=%b ready=%b expected Q=1110 ready=1", Q, ready);
        end
    endtask

    task automatic test_zero_shift();
        run_op(4'b0110, 3'd0, 1'b1, -1, "zero_shift");
    endtask

    task automatic test_clamp();
        run_op(4'b0011, 3'd7, 1'b0, -1, "clamp");
    endtask

    task automatic test_ignore_start();
        run_op(4'b1010, 3'd4, 1'b0, 2, "ignore_start");
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (Q !== 4'b0000 || ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL not_queued: got Q=%b ready=%b expected Q=0000 ready=1", Q, ready);
        end
    endtask

    task automatic test_reset_mid();
        start   = 1'b1;
        data_in = 4'b1010;
        nshift  = 3'd4;
        fill    = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (Q !== 4'b0010 || sout_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_before_reset: got Q=%b sv=%b expected Q=0010 sv=1", Q, sout_valid);
        end
        Resetn = 1'b0;
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || sout_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_outputs: got ready=%b done=%b sv=%b busy=%b expected 1 0 0 0",
                     ready, done, sout_valid, busy);
        end
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (Q !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL mid_reset_frozen: got %b expected 0010", Q);
        end
        Resetn = 1'b1;
        step();
        checks++;
        if (Q !== 4'b0010 || ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL after_release: got Q=%b ready=%b expected Q=0010 ready=1", Q, ready);
        end
        run_op(4'b0101, 3'd3, 1'b1, -1, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_op(WIDTH'($urandom), CW'($urandom_range(0, 7)), 1'($urandom), -1, "back_to_back");
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_full_shift();
        test_hold();
        test_zero_shift();
        test_clamp();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
